// File: rtl/rom_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arb_pkg
//  Description : Shared types and default constants for the two-port ROM read
//                arbiter (fetch port / load port sharing one ROM read port).
//  Revision    : 1.0 - initial release
// ============================================================================
package rom_arb_pkg;

   // Default build parameters.
   localparam int unsigned c_DATA_WIDTH = 16;
   localparam int unsigned c_ADDR_WIDTH = 8;
   localparam int unsigned c_ROM_DEPTH  = 256;
   localparam int unsigned c_LATENCY    = 1;

   // Requester identity carried alongside each in-flight read.
   typedef enum logic {
      PORT_FETCH = 1'b0,
      PORT_LOAD  = 1'b1
   } port_id_t;

   // One pipeline slot: valid read, who asked, and whether it bypassed the ROM.
   typedef struct packed {
      logic     valid;
      port_id_t port;
      logic     oor;
   } rom_tag_t;

   localparam rom_tag_t c_TAG_IDLE = '{valid: 1'b0, port: PORT_FETCH, oor: 1'b0};

   // Unsigned range check; an address at or beyond the depth never reaches the ROM.
   function automatic logic addr_oor(input logic [31:0] addr, input int unsigned depth);
      return (addr >= depth);
   endfunction

endpackage
`default_nettype wire

// File: rtl/rom_arb_tag_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arb_tag_pipe
//  Description : LATENCY-deep shift register of read tags. The tag leaving the
//                last stage lines up with the ROM data for the same read.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_arb_tag_pipe
   import rom_arb_pkg::*;
#(
   parameter int unsigned LATENCY = c_LATENCY
) (
   input  logic     clk,
   input  logic     rst,
   input  rom_tag_t tag_in,
   output rom_tag_t tag_out
);

   rom_tag_t r_stage [LATENCY];

   // Shift one stage per cycle; reset discards every in-flight read.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(LATENCY); i++) begin
            r_stage[i] <= c_TAG_IDLE;
         end
      end else begin
         r_stage[0] <= tag_in;
         for (int i = 1; i < int'(LATENCY); i++) begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign tag_out = r_stage[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/rom_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rom_arbiter
//  Description : Round-robin arbiter letting the fetch port (0) and load port
//                (1) share one ROM read port. One read per cycle, responses
//                routed back in order, out-of-range reads answered with an
//                error without touching the ROM. LATENCY legal range 1..4.
//  Revision    : 1.0 - initial release
// ============================================================================
module rom_arbiter
   import rom_arb_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = c_ADDR_WIDTH,
   parameter int unsigned ROM_DEPTH  = c_ROM_DEPTH,
   parameter int unsigned LATENCY    = c_LATENCY
) (
   input  logic                  clk,
   input  logic                  rst,
   // request port 0 (fetch)
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   output logic                  req0_ready,
   // request port 1 (load)
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   output logic                  req1_ready,
   // response port 0
   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_data,
   output logic                  rsp0_error,
   // response port 1
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_data,
   output logic                  rsp1_error,
   // shared ROM read port
   output logic                  rom_en,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   input  logic [DATA_WIDTH-1:0] rom_data,
   input  logic                  rom_error
);

   logic                  r_prio;       // 0: port 0 wins a tie, 1: port 1 wins
   logic                  w_gnt0;
   logic                  w_gnt1;
   logic                  w_gnt_any;
   logic [ADDR_WIDTH-1:0] w_gnt_addr;
   logic                  w_gnt_oor;
   logic                  w_oor0;
   logic                  w_oor1;
   rom_tag_t              w_tag_in;
   rom_tag_t              w_tag_out;
   logic [DATA_WIDTH-1:0] w_rsp_data;
   logic                  w_rsp_error;

   // Range checks; with ROM_DEPTH = 2^ADDR_WIDTH these are constant false.
   assign w_oor0 = addr_oor(32'(req0_addr), ROM_DEPTH);
   assign w_oor1 = addr_oor(32'(req1_addr), ROM_DEPTH);

   // Grant selection: a lone requester wins, a tie goes to the prio port,
   // and reset suppresses every grant.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         if (req0_valid && (!req1_valid || (r_prio == 1'b0))) begin
            w_gnt0 = 1'b1;
         end else if (req1_valid) begin
            w_gnt1 = 1'b1;
         end
      end
   end

   assign w_gnt_any  = w_gnt0 | w_gnt1;
   assign req0_ready = w_gnt0;
   assign req1_ready = w_gnt1;

   // Address and range flag of whichever request was granted this cycle.
   always_comb begin
      w_gnt_addr = '0;
      w_gnt_oor  = 1'b0;
      if (w_gnt0) begin
         w_gnt_addr = req0_addr;
         w_gnt_oor  = w_oor0;
      end else if (w_gnt1) begin
         w_gnt_addr = req1_addr;
         w_gnt_oor  = w_oor1;
      end
   end

   // An out-of-range grant keeps its pipeline slot but never strobes the ROM.
   assign rom_en   = w_gnt_any & ~w_gnt_oor;
   assign rom_addr = rom_en ? w_gnt_addr : '0;

   // Round-robin pointer: after a grant the other port gets the next tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prio <= 1'b0;
      end else if (w_gnt0) begin
         r_prio <= 1'b1;
      end else if (w_gnt1) begin
         r_prio <= 1'b0;
      end
   end

   // Idle cycles push an invalid tag so slot timing always matches the ROM.
   assign w_tag_in = '{valid: w_gnt_any,
                       port:  (w_gnt1 ? PORT_LOAD : PORT_FETCH),
                       oor:   w_gnt_oor};

   rom_arb_tag_pipe #(
      .LATENCY (LATENCY)
   ) u_tag_pipe (
      .clk     (clk),
      .rst     (rst),
      .tag_in  (w_tag_in),
      .tag_out (w_tag_out)
   );

   // The ROM's own error is irrelevant for a read that never reached it.
   assign w_rsp_data  = w_tag_out.oor ? '0 : rom_data;
   assign w_rsp_error = w_tag_out.oor | rom_error;

   // Response registers: one-cycle pulse on the tagged port, zeros otherwise.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_error <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_error <= 1'b0;
      end else begin
         rsp0_valid <= 1'b0;
         rsp0_data  <= '0;
         rsp0_error <= 1'b0;
         rsp1_valid <= 1'b0;
         rsp1_data  <= '0;
         rsp1_error <= 1'b0;
         if (w_tag_out.valid) begin
            if (w_tag_out.port == PORT_FETCH) begin
               rsp0_valid <= 1'b1;
               rsp0_data  <= w_rsp_data;
               rsp0_error <= w_rsp_error;
            end else begin
               rsp1_valid <= 1'b1;
               rsp1_data  <= w_rsp_data;
               rsp1_error <= w_rsp_error;
            end
         end
      end
   end

endmodule
`default_nettype wire
